seq_restoring_divider: RTL



---
 rtl/seq_restoring_divider.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (sign fix-up around the unsigned core).

module seq_restoring_divider_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p, q, d;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] nd, diff_lo, p_nxt, q_nxt;
    logic [NSLICE:0]  c;
    logic             ge;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

    // Trial subtraction T - D as T + ~D + 1, rippled through 4-bit slices.
    assign t    = {p, q[WIDTH-1]};
    assign nd   = ~d;
    assign c[0] = 1'b1;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        seq_restoring_divider_add4 u_add4 (
            .a  (t[4*i +: 4]),
            .b  (nd[4*i +: 4]),
            .ci (c[i]),
            .s  (diff_lo[4*i +: 4]),
            .co (c[i+1])
        );
    end

    // Top bit of the WIDTH+1 subtract: D's extension bit is 0, so ~D contributes 1.
    assign ge    = t[WIDTH] | c[NSLICE];
    assign p_nxt = ge ? diff_lo : t[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], ge};

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix = neg_q ? -q_nxt : q_nxt;
    assign r_fix = neg_r ? -p_nxt : p_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_nxt;
    assign r_fix = p_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    div_by_zero <= 1'b0;
                    if (divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        cnt <= CW'(WIDTH);
                        p   <= '0;
                        q   <= a_mag;
                        d   <= b_mag;
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
